// File: rtl/switch_mcu_pkg.sv
// Shared definitions for the switch MCU register file and its read ports.
// Holds the default geometry, the hard-wired zero register index and FSM encodings.
// No logic; imported by every regfile file.
package switch_mcu_pkg;

  localparam int P_DW     = 32;
  localparam int P_AW     = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/switch_mcu_regfile_rport.sv
// One registered read port: x0 mask, write-first bypass, one-cycle valid pulse.
// Latency: data and valid registered at the edge that samples the request.
// Backpressure: none; a request is accepted every cycle.
module switch_mcu_regfile_rport
  import switch_mcu_pkg::*;
#(
  parameter int P_DW = switch_mcu_pkg::P_DW,
  parameter int P_AW = switch_mcu_pkg::P_AW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            ren_i,
  input  logic [P_AW-1:0] raddr_i,
  input  logic            wen_i,
  input  logic [P_AW-1:0] waddr_i,
  input  logic [P_DW-1:0] wdata_i,
  input  logic [P_DW-1:0] mem_rdata_i,
  output logic [P_DW-1:0] rdata_o,
  output logic            rvalid_o
);

  logic [P_DW-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            is_zero;
  logic            is_bypass;

  // wen_i arrives already qualified (running, non-zero address), so a match
  // here means the array entry is being overwritten at this very edge.
  assign is_zero   = (raddr_i == P_AW'(REG_ZERO));
  assign is_bypass = wen_i && (waddr_i == raddr_i);

  // Next read data: hold when idle; zero during the sweep or for x0; else bypass or array.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (ren_i) begin
      rvalid_d = 1'b1;
      if (clear_i || is_zero) begin
        rdata_d = '0;
      end else if (is_bypass) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_rdata_i;
      end
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/switch_mcu_regfile.sv
// General-purpose register file: 2 registered read ports, 1 write port, x0 = 0, post-reset clear sweep.
// Latency: reads 1 cycle; writes land at the enabling edge; sweep takes 32 cycles after reset.
// Backpressure: none in S_RUN; user writes are dropped while out_busy is high.
module switch_mcu_regfile
  import switch_mcu_pkg::*;
#(
  parameter int P_DW = switch_mcu_pkg::P_DW,
  parameter int P_AW = switch_mcu_pkg::P_AW
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_ren_1,
  input  logic [P_AW-1:0] in_raddr_1,
  output logic [P_DW-1:0] out_rdata_1,
  output logic            out_rvalid_1,
  input  logic            in_ren_2,
  input  logic [P_AW-1:0] in_raddr_2,
  output logic [P_DW-1:0] out_rdata_2,
  output logic            out_rvalid_2,
  input  logic            in_wen,
  input  logic [P_AW-1:0] in_waddr,
  input  logic [P_DW-1:0] in_wdata,
  output logic            out_busy
);

  localparam int DEPTH = 2 ** P_AW;

  state_e          state_q;
  logic [P_AW-1:0] clr_idx_q;
  logic            busy_q;
  logic [P_DW-1:0] mem_q [DEPTH];
  logic            user_wr;
  logic            in_clear;

  assign in_clear = (state_q == S_CLEAR);

  // A user write only counts when running and not aimed at x0.
  assign user_wr = in_wen && !in_rst && (state_q == S_RUN) &&
                   (in_waddr != P_AW'(REG_ZERO));

  // Clear sequencer: sweep every entry once after reset, then run until the next reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == {P_AW{1'b1}}) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        default: begin
          state_q <= S_CLEAR;
        end
      endcase
    end
  end

  // Single write port shared by the sweep and user writes; no reset so it maps to a macro.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      if (in_clear) begin
        mem_q[clr_idx_q] <= '0;
      end else if (user_wr) begin
        mem_q[in_waddr] <= in_wdata;
      end
    end
  end

  switch_mcu_regfile_rport #(
    .P_DW(P_DW),
    .P_AW(P_AW)
  ) u_rport_1 (
    .clk_i      (in_clk),
    .rst_i      (in_rst),
    .clear_i    (in_clear),
    .ren_i      (in_ren_1),
    .raddr_i    (in_raddr_1),
    .wen_i      (user_wr),
    .waddr_i    (in_waddr),
    .wdata_i    (in_wdata),
    .mem_rdata_i(mem_q[in_raddr_1]),
    .rdata_o    (out_rdata_1),
    .rvalid_o   (out_rvalid_1)
  );

  switch_mcu_regfile_rport #(
    .P_DW(P_DW),
    .P_AW(P_AW)
  ) u_rport_2 (
    .clk_i      (in_clk),
    .rst_i      (in_rst),
    .clear_i    (in_clear),
    .ren_i      (in_ren_2),
    .raddr_i    (in_raddr_2),
    .wen_i      (user_wr),
    .waddr_i    (in_waddr),
    .wdata_i    (in_wdata),
    .mem_rdata_i(mem_q[in_raddr_2]),
    .rdata_o    (out_rdata_2),
    .rvalid_o   (out_rvalid_2)
  );

  assign out_busy = busy_q;

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// Scoreboard bench for switch_mcu_regfile: stimulus pushes expected read data,
// a negedge monitor pops and compares on every rvalid pulse.
// Direct checks cover busy timing and reset values.
module tb_switch_mcu_regfile;

  logic        in_clk;
  logic        in_rst;
  logic        in_ren_1;
  logic [4:0]  in_raddr_1;
  logic [31:0] out_rdata_1;
  logic        out_rvalid_1;
  logic        in_ren_2;
  logic [4:0]  in_raddr_2;
  logic [31:0] out_rdata_2;
  logic        out_rvalid_2;
  logic        in_wen;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        out_busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  switch_mcu_regfile #(
    .P_DW(32),
    .P_AW(5)
  ) dut (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_ren_1    (in_ren_1),
    .in_raddr_1  (in_raddr_1),
    .out_rdata_1 (out_rdata_1),
    .out_rvalid_1(out_rvalid_1),
    .in_ren_2    (in_ren_2),
    .in_raddr_2  (in_raddr_2),
    .out_rdata_2 (out_rdata_2),
    .out_rvalid_2(out_rvalid_2),
    .in_wen      (in_wen),
    .in_waddr    (in_waddr),
    .in_wdata    (in_wdata),
    .out_busy    (out_busy)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endfunction

  // Monitor: every rvalid pulse must match the oldest outstanding expectation.
  always @(negedge in_clk) begin
    if (out_rvalid_1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL port1_unexpected_rvalid: got data %08h expected no response", out_rdata_1);
      end else begin
        chk("port1_rdata", out_rdata_1, q1.pop_front());
      end
    end
    if (out_rvalid_2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL port2_unexpected_rvalid: got data %08h expected no response", out_rdata_2);
      end else begin
        chk("port2_rdata", out_rdata_2, q2.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle();
    in_ren_1 = 1'b0;
    in_ren_2 = 1'b0;
    in_wen   = 1'b0;
  endtask

  task automatic rd1(input logic [4:0] a, input logic [31:0] exp);
    in_ren_1   = 1'b1;
    in_raddr_1 = a;
    q1.push_back(exp);
  endtask

  task automatic rd2(input logic [4:0] a, input logic [31:0] exp);
    in_ren_2   = 1'b1;
    in_raddr_2 = a;
    q2.push_back(exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    in_wen   = 1'b1;
    in_waddr = a;
    in_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected run to end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_rst = 1'b1;
    idle();
    in_raddr_1 = '0;
    in_raddr_2 = '0;
    in_waddr   = '0;
    in_wdata   = '0;
    step();
    step();

    // Reset values.
    chk("reset_rdata_1", out_rdata_1, 32'h0);
    chk("reset_rdata_2", out_rdata_2, 32'h0);
    chk("reset_rvalid_1", {31'h0, out_rvalid_1}, 32'h0);
    chk("reset_busy", {31'h0, out_busy}, 32'h1);

    // Sweep: busy for exactly 32 cycles after reset release.
    in_rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("sweep_busy_high", {31'h0, out_busy}, 32'h1);
      step();
    end
    chk("sweep_busy_low", {31'h0, out_busy}, 32'h0);

    // Every entry reads zero on both ports, full rate.
    for (int a = 0; a < 32; a++) begin
      rd1(5'(a), 32'h0);
      rd2(5'(31 - a), 32'h0);
      step();
    end
    idle();
    step();

    // Write then read next cycle.
    wr(5'd5, 32'hDEADBEEF);
    step();
    idle();
    rd1(5'd5, 32'hDEADBEEF);
    step();
    idle();
    step();
    step();
    chk("hold_rdata_1", out_rdata_1, 32'hDEADBEEF);
    chk("idle_rvalid_1", {31'h0, out_rvalid_1}, 32'h0);

    // x0 protection: plain write, then same-cycle write+read of x0.
    wr(5'd0, 32'hFFFFFFFF);
    step();
    idle();
    rd1(5'd0, 32'h0);
    rd2(5'd0, 32'h0);
    step();
    wr(5'd0, 32'hFFFFFFFF);
    rd1(5'd0, 32'h0);
    rd2(5'd0, 32'h0);
    step();
    idle();

    // Write-first bypass on both ports.
    wr(5'd7, 32'h12345678);
    rd1(5'd7, 32'h12345678);
    rd2(5'd7, 32'h12345678);
    step();
    idle();
    // Back-to-back reads, mixed addresses.
    rd1(5'd7, 32'h12345678);
    rd2(5'd5, 32'hDEADBEEF);
    step();
    rd1(5'd5, 32'hDEADBEEF);
    rd2(5'd7, 32'h12345678);
    step();
    rd1(5'd0, 32'h0);
    in_ren_2 = 1'b0;
    step();
    idle();

    // Mid-run reset after writing x9.
    wr(5'd9, 32'h55);
    step();
    idle();
    rd1(5'd9, 32'h55);
    rd2(5'd9, 32'h55);
    step();
    idle();
    step();
    in_rst = 1'b1;
    step();
    chk("midrun_rst_rdata_1", out_rdata_1, 32'h0);
    chk("midrun_rst_rdata_2", out_rdata_2, 32'h0);
    chk("midrun_rst_busy", {31'h0, out_busy}, 32'h1);
    in_rst = 1'b0;

    // Let the sweep reach cycle 10, then reset again.
    for (int i = 0; i < 10; i++) begin
      chk("partial_sweep_busy", {31'h0, out_busy}, 32'h1);
      step();
    end
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;

    // Restarted sweep: full 32 busy cycles, blocked write, acknowledged reads.
    for (int i = 0; i < 32; i++) begin
      chk("restart_busy_high", {31'h0, out_busy}, 32'h1);
      idle();
      if (i == 5) rd2(5'd9, 32'h0);
      if (i == 20) wr(5'd3, 32'hAA);
      if (i == 25) rd1(5'd7, 32'h0);
      step();
    end
    idle();
    chk("restart_busy_low", {31'h0, out_busy}, 32'h0);

    // Everything cleared, blocked write did not land.
    rd1(5'd3, 32'h0);
    rd2(5'd9, 32'h0);
    step();
    rd1(5'd5, 32'h0);
    rd2(5'd7, 32'h0);
    step();
    idle();
    step();
    step();

    chk("q1_drained", 32'(q1.size()), 32'h0);
    chk("q2_drained", 32'(q2.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_mcu_regfile.md
# switch_mcu_regfile

General-purpose register file serving the switch MCU execute units: the responder end of the read-port/write-port interface that the ALU slices drive. Two registered read ports, one write port, x0 hard-wired to zero. A post-reset clear sequencer sweeps all 32 entries one per cycle, so the array can map to a single-write-port memory macro. Sits between the decoder/ALU slices and the architectural state.

## Interface
- `P_DW`, default 32: data width.
- `P_AW`, default 5: address width; depth is 2^P_AW = 32.
- `in_clk`  input  1  clock.
- `in_rst`  input  1  reset; synchronous, active-high.
- `in_ren_1`  input  1  read enable, port 1.
- `in_raddr_1`  input  P_AW  read address, port 1.
- `out_rdata_1`  output  P_DW  read data, port 1.
- `out_rvalid_1`  output  1  one-cycle pulse: out_rdata_1 updated.
- `in_ren_2`  input  1  read enable, port 2.
- `in_raddr_2`  input  P_AW  read address, port 2.
- `out_rdata_2`  output  P_DW  read data, port 2.
- `out_rvalid_2`  output  1  one-cycle pulse: out_rdata_2 updated.
- `in_wen`  input  1  write enable.
- `in_waddr`  input  P_AW  write address.
- `in_wdata`  input  P_DW  write data.
- `out_busy`  output  1  high while the clear sweep runs.

## Operation
- Single clock and reset: one clock (`in_clk`); reset (`in_rst`) is synchronous and active-high.
- FSM states:
  - S_CLEAR: an internal counter `clr_idx` (P_AW bits) writes 0 to entry `clr_idx` each cycle and increments. On `clr_idx == 31` the FSM writes entry 31 and moves to S_RUN next cycle.
  - S_RUN: normal operation; the FSM never leaves S_RUN except on reset.
- Reset (asserted in any state, including mid-sweep): next state S_CLEAR, `clr_idx` = 0, all outputs 0, `out_busy` = 1.
- Reads in S_RUN: when `in_renN`=1, sample the address. On the next edge `out_rdataN` = entry value and `out_rvalidN` = 1 for exactly one cycle. With `in_renN`=0, `out_rdataN` holds its previous value and `out_rvalidN` = 0.
- Reads in S_CLEAR: `out_rdataN` = 0 and `out_rvalidN` = 1. The request is acknowledged but carries no data.
- Writes in S_RUN: on `in_wen`=1 and `in_waddr` != 0, the entry takes `in_wdata` at the edge. A write to address 0 is silently dropped.
- Writes in S_CLEAR: user writes are ignored; the sweep has priority. The driver must hold off until `out_busy` = 0.
- Address 0 reads return 0 in every state.
- Same-cycle read and write to the same non-zero address (write-first bypass): the read returns `in_wdata`. Both ports may bypass at once.
- Both read ports at the same address: both return identical data in the same cycle.

## Timing
- Read latency: 1 cycle from the request edge to `out_rdata`/`out_rvalid`. An ALU that asserts `ren` in its cycle 1 (registered, so seen here during its cycle 2) has valid data from its cycle 3 onward, and that data is held stable.
- Write latency: the entry is updated at the edge where `in_wen`=1. A read issued in the following cycle sees the new value.
- Clear sweep: 32 cycles after reset deassertion. `out_busy` falls in the cycle after entry 31 is cleared.
- Reset values: `out_rdata_1/2` = 0, `out_rvalid_1/2` = 0, `out_busy` = 1.
- No backpressure: reads and writes are accepted every cycle in S_RUN, with back-to-back reads at full rate.

## Structure
- Shared package `switch_mcu_pkg`: `P_DW`, `P_AW`, register index constant `REG_ZERO` = 0, FSM state encodings `S_CLEAR`/`S_RUN`.
- One natural sub-module, `switch_mcu_regfile_rport`: a single read port containing the address register, bypass compare, x0 mask and valid pulse. It is instantiated twice. The array, write logic and clear FSM stay in the top module.

## Test plan
- Reset then idle: `out_busy` = 1 for 32 cycles then 0; afterwards, reading addresses 0..31 on both ports returns 0 with a `rvalid` pulse for each read.
- Write then read: write x5 = 0xDEADBEEF; read x5 on port 1 the next cycle -> `out_rdata_1` = 0xDEADBEEF one cycle later with `out_rvalid_1` = 1.
- x0 protection: write x0 = 0xFFFFFFFF; read x0 on both ports -> 0.
- Bypass: in one cycle, write x7 = 0x12345678 and read x7 on ports 1 and 2 -> both return 0x12345678.
- Mid-sweep reset and write blocking: assert `in_rst` at sweep cycle 10 -> sweep restarts with 32 more busy cycles. Write x3 = 0xAA while busy -> x3 reads 0 after the sweep.
- Mid-run reset: write x9 = 0x55 in S_RUN, pulse `in_rst` -> after the sweep, x9 reads 0 and both `out_rdata` outputs read 0 during reset.
